nw_mod_counter: RTL

//  Parametrised modulo-(MAX+1) event counter for the NW datapath control; generalises the fixed mod-3 stepper.

---
 rtl/nw_mod_counter.sv | 80 ++++++++
 1 files changed

// File: rtl/nw_mod_counter.sv
// Modulo-(MAX+1) event counter with terminal-count flag, wrap pulse, sticky done and epoch count.
// Optional synchronous load (ld/ld_val) is built only when NW_CNT_LOAD_EN is defined.
module nw_mod_counter #(
    parameter int WIDTH    = 2,
    parameter int MAX      = 2,
    parameter int SATURATE = 0,
    parameter int EPOCH_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
`ifdef NW_CNT_LOAD_EN
    input  logic               ld,
    input  logic [WIDTH-1:0]   ld_val,
`endif
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               wrap_p,
    output logic               done,
    output logic [EPOCH_W-1:0] epoch
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    generate
        if (MAX < 1 || MAX >= (1 << WIDTH)) begin : g_bad_cfg
            $error("nw_mod_counter: MAX must satisfy 1 <= MAX < 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0]   nxt_count;
    logic               nxt_wrap;
    logic [EPOCH_W-1:0] nxt_epoch;

    // Edge priority: clr, then load, then enable, otherwise hold.
    always_comb begin
        nxt_count = count;
        nxt_wrap  = 1'b0;
        nxt_epoch = epoch;
        if (clr) begin
            nxt_count = '0;
            nxt_epoch = '0;
        end
`ifdef NW_CNT_LOAD_EN
        else if (ld) begin
            nxt_count = (ld_val > MAX_V) ? MAX_V : ld_val;
        end
`endif
        else if (en) begin
            if (count == MAX_V) begin
                if (SATURATE == 0) begin
                    nxt_count = '0;
                    nxt_wrap  = 1'b1;
                    nxt_epoch = epoch + 1'b1;
                end
            end else begin
                nxt_count = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wrap_p <= 1'b0;
            done   <= 1'b0;
            epoch  <= '0;
        end else begin
            count  <= nxt_count;
            wrap_p <= nxt_wrap;
            epoch  <= nxt_epoch;
            // Sticky until clr; a clear always lands on 0, which is never MAX.
            done   <= !clr && (done || (nxt_count == MAX_V));
        end
    end

    assign tc = (count == MAX_V);

endmodule
